// File: rtl/acc_cpu_pkg.sv
// Shared definitions for the accumulator core: opcodes, FSM states, ALU selects.
// Optional feature macro: ACC_CPU_INDIRECT_EN (adds the INDIR state).
package acc_cpu_pkg;

   localparam int OPC_W = 3;

   localparam logic [OPC_W-1:0] OP_LDA = 3'b000;
   localparam logic [OPC_W-1:0] OP_ADD = 3'b001;
   localparam logic [OPC_W-1:0] OP_STA = 3'b010;
   localparam logic [OPC_W-1:0] OP_JMP = 3'b011;
   localparam logic [OPC_W-1:0] OP_SUB = 3'b100;
   localparam logic [OPC_W-1:0] OP_AND = 3'b101;
   localparam logic [OPC_W-1:0] OP_JZ  = 3'b110;
   localparam logic [OPC_W-1:0] OP_HLT = 3'b111;

   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
`ifdef ACC_CPU_INDIRECT_EN
      ST_INDIR  = 3'd4,
`endif
      ST_HALT   = 3'd3
   } state_e;

   typedef enum logic [1:0] {
      ALU_PASS = 2'd0,
      ALU_ADD  = 2'd1,
      ALU_SUB  = 2'd2,
      ALU_AND  = 2'd3
   } alu_op_e;

   // Map an opcode to the ALU operation used when its memory operand arrives.
   function automatic alu_op_e alu_sel(input logic [OPC_W-1:0] op);
      case (op)
         OP_ADD:  return ALU_ADD;
         OP_SUB:  return ALU_SUB;
         OP_AND:  return ALU_AND;
         default: return ALU_PASS;
      endcase
   endfunction

endpackage

// File: rtl/acc_cpu_alu.sv
// Combinational ALU: PASS (load), ADD, SUB (borrow as carry-out), AND.
module acc_cpu_alu
   import acc_cpu_pkg::*;
#(
   parameter int DATA_W = 16
) (
   input  logic [1:0]        i_op,
   input  logic [DATA_W-1:0] i_a,
   input  logic [DATA_W-1:0] i_b,
   output logic [DATA_W-1:0] o_res,
   output logic              o_c
);

   logic [DATA_W:0] w_ext;

   // One extra bit carries the add carry / subtract borrow.
   always_comb begin
      w_ext = '0;
      case (alu_op_e'(i_op))
         ALU_ADD: w_ext = {1'b0, i_a} + {1'b0, i_b};
         ALU_SUB: w_ext = {1'b0, i_a} - {1'b0, i_b};
         ALU_AND: w_ext = {1'b0, i_a & i_b};
         default: w_ext = {1'b0, i_b};
      endcase
   end

   assign o_res = w_ext[DATA_W-1:0];
   assign o_c   = w_ext[DATA_W];

endmodule

// File: rtl/acc_cpu_core.sv
// Accumulator core: fetch/decode/execute FSM over a single req/ack memory port.
// Optional feature macro: ACC_CPU_INDIRECT_EN (indirect bit ir[DATA_W-4], INDIR state).
module acc_cpu_core
   import acc_cpu_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int ADR_W  = 12,
   parameter int RST_PC = 0
) (
   input  logic              clk,
   input  logic              rst,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADR_W-1:0]  mem_adr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack,
   output logic [OPC_W-1:0]  op_code,
   output logic [DATA_W-1:0] ac_out,
   output logic [ADR_W-1:0]  pc_out,
   output logic              flag_z,
   output logic              flag_c,
   output logic              halted
);

`ifdef ACC_CPU_INDIRECT_EN
   if (DATA_W < ADR_W + OPC_W + 1) begin : g_bad_width
      $error("acc_cpu_core: DATA_W must be >= ADR_W+4 with indirect addressing");
   end
`else
   if (DATA_W < ADR_W + OPC_W) begin : g_bad_width
      $error("acc_cpu_core: DATA_W must be >= ADR_W+3");
   end
`endif
   if (RST_PC < 0 || RST_PC >= (2 ** ADR_W)) begin : g_bad_rst_pc
      $error("acc_cpu_core: RST_PC does not fit in ADR_W");
   end

   localparam logic [ADR_W-1:0] LP_RST_PC = RST_PC[ADR_W-1:0];

   state_e            r_state, w_nxt;
   // Only the instruction fields the core acts on are held in IR.
   logic [OPC_W-1:0]  r_op;
   logic [ADR_W-1:0]  r_iadr;
   logic [ADR_W-1:0]  r_pc;
   logic [DATA_W-1:0] r_ac;
   logic              r_z, r_c;
   logic              w_ack, w_we, w_ac_zero, w_take, w_jump_now, w_busy;
   logic [ADR_W-1:0]  w_adr, w_exec_adr;
   logic [DATA_W-1:0] w_alu_res;
   logic              w_alu_c;
`ifdef ACC_CPU_INDIRECT_EN
   logic              r_ind;
   logic [ADR_W-1:0]  r_ea;
`endif

   assign w_ac_zero = (r_ac == '0);
   assign w_take    = (r_op == OP_JMP) || ((r_op == OP_JZ) && w_ac_zero);
`ifdef ACC_CPU_INDIRECT_EN
   assign w_exec_adr = r_ea;
   assign w_jump_now = w_take && !r_ind;
   assign w_busy     = (r_state == ST_FETCH) || (r_state == ST_EXEC) || (r_state == ST_INDIR);
`else
   assign w_exec_adr = r_iadr;
   assign w_jump_now = w_take;
   assign w_busy     = (r_state == ST_FETCH) || (r_state == ST_EXEC);
`endif

   // Request drops combinationally with reset so an in-flight access is abandoned at once.
   assign mem_req = w_busy && rst;
   assign w_ack   = mem_req && mem_ack;

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= ST_FETCH;
      else      r_state <= w_nxt;
   end

   // Next-state and memory port address/direction.
   always_comb begin
      w_nxt = r_state;
      w_we  = 1'b0;
      w_adr = r_pc;
      case (r_state)
         ST_FETCH: if (w_ack) w_nxt = ST_DECODE;
         ST_DECODE: begin
            case (r_op)
               OP_JMP:  w_nxt = ST_FETCH;
               OP_JZ:   w_nxt = ST_FETCH;
               OP_HLT:  w_nxt = ST_HALT;
               default: w_nxt = ST_EXEC;
            endcase
`ifdef ACC_CPU_INDIRECT_EN
            // A JZ that will not be taken needs no pointer, so it skips INDIR.
            if (r_ind && (r_op != OP_HLT) && !((r_op == OP_JZ) && !w_ac_zero))
               w_nxt = ST_INDIR;
`endif
         end
         ST_EXEC: begin
            w_adr = w_exec_adr;
            w_we  = (r_op == OP_STA);
            if (w_ack) w_nxt = ST_FETCH;
         end
`ifdef ACC_CPU_INDIRECT_EN
         ST_INDIR: begin
            w_adr = r_iadr;
            if (w_ack) w_nxt = ((r_op == OP_JMP) || (r_op == OP_JZ)) ? ST_FETCH : ST_EXEC;
         end
`endif
         ST_HALT: w_nxt = ST_HALT;
         default: w_nxt = ST_FETCH;
      endcase
   end

   acc_cpu_alu #(.DATA_W(DATA_W)) u_alu (
      .i_op  (alu_sel(r_op)),
      .i_a   (r_ac),
      .i_b   (mem_rdata),
      .o_res (w_alu_res),
      .o_c   (w_alu_c)
   );

   // Datapath: IR/PC on fetch, jumps on decode, AC/flags on execute.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_op   <= '0;
         r_iadr <= '0;
         r_pc   <= LP_RST_PC;
         r_ac   <= '0;
         r_z    <= 1'b0;
         r_c    <= 1'b0;
`ifdef ACC_CPU_INDIRECT_EN
         r_ind  <= 1'b0;
         r_ea   <= '0;
`endif
      end else begin
         case (r_state)
            ST_FETCH: if (w_ack) begin
               r_op   <= mem_rdata[DATA_W-1 -: OPC_W];
               r_iadr <= mem_rdata[ADR_W-1:0];
`ifdef ACC_CPU_INDIRECT_EN
               r_ind  <= mem_rdata[DATA_W-4];
`endif
               r_pc   <= r_pc + ADR_W'(1);
            end
            ST_DECODE: begin
`ifdef ACC_CPU_INDIRECT_EN
               r_ea <= r_iadr;
`endif
               if (w_jump_now) r_pc <= r_iadr;
            end
            ST_EXEC: if (w_ack && (r_op != OP_STA)) begin
               r_ac <= w_alu_res;
               r_z  <= (w_alu_res == '0);
               if ((r_op == OP_ADD) || (r_op == OP_SUB)) r_c <= w_alu_c;
            end
`ifdef ACC_CPU_INDIRECT_EN
            ST_INDIR: if (w_ack) begin
               if ((r_op == OP_JMP) || (r_op == OP_JZ)) r_pc <= mem_rdata[ADR_W-1:0];
               else                                     r_ea <= mem_rdata[ADR_W-1:0];
            end
`endif
            default: ;
         endcase
      end
   end

   assign mem_we    = w_we;
   assign mem_adr   = w_adr;
   assign mem_wdata = r_ac;
   assign op_code   = r_op;
   assign ac_out    = r_ac;
   assign pc_out    = r_pc;
   assign flag_z    = r_z;
   assign flag_c    = r_c;
   assign halted    = (r_state == ST_HALT);

endmodule

// File: doc/acc_cpu_core.md
Name: acc_cpu_core

Overview:
Parametrised next-generation accumulator datapath for the adding machine, with its sequencing controller folded in. It fetches instructions from a single shared memory port with a req/ack handshake that tolerates wait states, then executes an 8-opcode accumulator ISA. It keeps Z/C status flags and halts on HLT. It sits between the top level and the unified program/data memory.

Parameters:
DATA_W, 16, word/accumulator width; instruction word width
ADR_W, 12, address width; PC width; instruction address field = ir[ADR_W-1:0]
RST_PC, 0, PC value loaded on reset (must fit in ADR_W)

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous, active-low reset
mem_req  out  1  memory request; held until mem_ack is sampled high
mem_we  out  1  1 = write (STA), 0 = read
mem_adr  out  ADR_W  request address; stable while mem_req = 1
mem_wdata  out  DATA_W  write data (= AC); stable while mem_req = 1
mem_rdata  in  DATA_W  read data; valid in the cycle mem_ack = 1
mem_ack  in  1  transfer completes on the clk edge where mem_req & mem_ack
op_code  out  3  ir[DATA_W-1:DATA_W-3]
ac_out  out  DATA_W  accumulator
pc_out  out  ADR_W  program counter
flag_z  out  1  zero flag
flag_c  out  1  carry/borrow flag
halted  out  1  core is in HALT

Behaviour:
- Constraint: DATA_W >= ADR_W+3; violation is an elaboration error. Bits between the opcode and the address field are ignored unless the optional feature is enabled.
- Opcodes: 000 LDA, 001 ADD, 010 STA, 011 JMP, 100 SUB, 101 AND, 110 JZ, 111 HLT. The low two bits of 000-011 match the 2-bit machine.
- Reset (async, rst=0):
  - PC=RST_PC; AC, IR, flags = 0; state=FETCH.
  - mem_req=0 and halted=0 immediately.
  - A transaction in flight is abandoned; a late ack is ignored.
- FSM states: FETCH, DECODE, EXEC, HALT (plus INDIR if the optional feature is enabled).
- FETCH: req=1, we=0, adr=PC. On ack: IR<=rdata, PC<=PC+1 mod 2^ADR_W, go to DECODE.
- DECODE (1 cycle, req=0):
  - JMP: PC<=ir adr, go to FETCH.
  - JZ: if AC==0 then PC<=ir adr; go to FETCH either way.
  - HLT: go to HALT.
  - All other opcodes: go to EXEC.
- EXEC: req=1, adr=ir adr, we=(op==STA), wdata=AC. On ack:
  - LDA: AC<=rdata.
  - ADD: {C,AC}<=AC+rdata, with a DATA_W+1-bit sum.
  - SUB: AC<=AC-rdata; C=1 on borrow.
  - AND: AC<=AC&rdata.
  - STA: AC unchanged.
  - Then go to FETCH.
- Flags:
  - Z<=(new AC==0) on every AC write.
  - C is written only by ADD/SUB.
  - LDA/AND leave C unchanged; STA/JMP/JZ leave both flags unchanged.
- Timing with zero-wait memory (ack in the same cycle as req): LDA/ADD/SUB/AND/STA take 3 cycles; JMP/JZ/HLT take 2. Each wait cycle adds 1.
- mem_ack while mem_req=0 is ignored.
- HALT: req=0, halted=1. Only reset leaves HALT.
- PC wraps 2^ADR_W-1 -> 0 silently.

Optional Feature:
ACC_CPU_INDIRECT_EN
- Defined: ir[DATA_W-4] is the indirect bit I (requires DATA_W >= ADR_W+4, else elaboration error).
  - For LDA/ADD/SUB/AND/STA/JMP/JZ with I=1, DECODE goes to INDIR.
  - INDIR: read at ir adr; on ack, EA<=rdata[ADR_W-1:0], then continue as EXEC (or apply the jump) using EA.
  - Adds exactly one memory transaction. JZ with I=1 and AC!=0 skips INDIR.
- Undefined: I is ignored; all addressing is direct; no INDIR state or EA register.

Decomposition:
- Package acc_cpu_pkg:
  - opcode localparams (OP_LDA..OP_HLT)
  - FSM state enum/encoding
  - opcode field width (3)
  - ALU op select encoding
- One sub-module, acc_cpu_alu: combinational PASS/ADD/SUB/AND with carry-out, DATA_W parametrised.
- FSM, PC, IR, AC, flags and memory mux stay in acc_cpu_core.

Test Plan:
- Basic program:
  - Stimulus: mem[0]=0x0010, mem[1]=0x2011, mem[2]=0x4012, mem[3]=0xE000, mem[0x10]=5, mem[0x11]=7, zero-wait memory.
  - Required: mem[0x12]=0x000C, halted=1 at cycle 11, pc_out=4, Z=0, C=0.
- Carry and borrow:
  - Stimulus: AC=0xFFFF, ADD a word of 0x0001.
  - Required: AC=0, Z=1, C=1.
  - Stimulus: LDA 3, SUB a word of 5.
  - Required: AC=0xFFFE, C=1, Z=0.
- JZ:
  - Stimulus: AC=0, JZ 0x020.
  - Required: next fetch adr=0x020.
  - Stimulus: AC=1, JZ 0x020.
  - Required: fetch continues at PC+1.
- Wait states:
  - Stimulus: ack delayed 3 cycles on every access.
  - Required: mem_req, mem_adr, mem_we, mem_wdata held stable throughout; the basic program completes in 11+3×7=32 cycles with the same result.
- Wrap and reset:
  - Stimulus: JMP 0xFFF, where mem[0xFFF] holds LDA.
  - Required: pc_out=0x000 after that fetch.
  - Stimulus: drop rst during a fetch wait.
  - Required: mem_req=0 in the same cycle; pc_out=RST_PC; subsequent stray ack has no effect.
- Indirect (macro on):
  - Stimulus: mem[0]=0x1010 (LDA, I=1), mem[0x10]=0x0020, mem[0x20]=0x1234.
  - Required: AC=0x1234 after 4 zero-wait cycles.
